// File: rtl/seq_match_window_counter.sv
// -----------------------------------------------------------------------------
// seq_match_window_counter
//
// Counts match pulses from the serial sequence detector over back-to-back
// windows of WINDOW bit-cycles and hands one saturating count report per
// window to the status/logging stage over a valid/ready interface. A report
// that arrives while the previous one is still unconsumed is dropped and the
// sticky ovf flag is raised.
//
// Optional feature (macro MATCH_GAP_EN): adds rpt_min_gap, the minimum
// distance in cycles between consecutive matches inside the reported window
// (all-ones when the window held fewer than two matches).
// -----------------------------------------------------------------------------
module seq_match_window_counter #(
    parameter int WINDOW = 16,
    parameter int CW     = 4,
    parameter int GW     = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          match_in,
    input  logic          rpt_ready,
    output logic          rpt_valid,
    output logic [CW-1:0] rpt_count,
    output logic          rpt_sat,
    output logic          ovf
`ifdef MATCH_GAP_EN
    ,
    output logic [GW-1:0] rpt_min_gap
`endif
);

    localparam int            PW       = $clog2(WINDOW);
    localparam logic [PW-1:0] POS_LAST = PW'(WINDOW - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    // Reject configurations where the window is too short or a gap could
    // reach the all-ones "no gap" code.
    generate
        if (WINDOW < 2 || (1 << GW) <= WINDOW) begin : g_bad_params
            $error("seq_match_window_counter: need WINDOW >= 2 and 2**GW > WINDOW");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    logic [PW-1:0] pos;
    logic [CW-1:0] cnt;
    logic          sat;

    logic          counting;
    logic          hit;
    logic          win_end;
    logic [CW-1:0] cnt_next;
    logic          sat_next;
    logic          load;
    logic          drop;

`ifdef MATCH_GAP_EN
    logic [PW-1:0] last_pos;
    logic          seen;
    logic [GW-1:0] min_gap;
    logic [GW-1:0] gap_cur;
    logic [GW-1:0] gap_next;
`endif

    // Per-cycle window arithmetic: what the count/sat (and min gap) become
    // once this cycle's match is included, and whether this is the last bit.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        counting = (state == RUN) && en;
        hit      = counting && match_in;
        win_end  = counting && (pos == POS_LAST);
        cnt_next = cnt;
        sat_next = sat;
        if (hit) begin
            if (cnt == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
        load = win_end && (!rpt_valid || rpt_ready);
        drop = win_end && rpt_valid && !rpt_ready;
`ifdef MATCH_GAP_EN
        gap_cur  = GW'(pos) - GW'(last_pos);
        gap_next = min_gap;
        if (hit && seen && (gap_cur < min_gap)) begin
            gap_next = gap_cur;
        end
`endif
    end

    // Window FSM: IDLE holds the window cleared; RUN advances pos every cycle,
    // wraps at the last bit and discards the partial window when en drops.
    // NOTE: the asynchronous reset is in the sensitivity list so state clears
    // without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pos   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    pos <= '0;
                    cnt <= '0;
                    sat <= 1'b0;
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                        pos   <= '0;
                        cnt   <= '0;
                        sat   <= 1'b0;
                    end else if (win_end) begin
                        pos <= '0;
                        cnt <= '0;
                        sat <= 1'b0;
                    end else begin
                        pos <= pos + 1'b1;
                        cnt <= cnt_next;
                        sat <= sat_next;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MATCH_GAP_EN
    // Gap tracker: remembers the position of the last match in the current
    // window and folds each new distance into the running minimum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_pos <= '0;
            seen     <= 1'b0;
            min_gap  <= '1;
        end else if (!counting || win_end) begin
            last_pos <= '0;
            seen     <= 1'b0;
            min_gap  <= '1;
        end else if (hit) begin
            last_pos <= pos;
            seen     <= 1'b1;
            min_gap  <= gap_next;
        end
    end
`endif

    // Report register: loads at window end when empty or being consumed,
    // otherwise drops the new report and raises the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_valid   <= 1'b0;
            rpt_count   <= '0;
            rpt_sat     <= 1'b0;
            ovf         <= 1'b0;
`ifdef MATCH_GAP_EN
            rpt_min_gap <= '1;
`endif
        end else if (load) begin
            rpt_valid   <= 1'b1;
            rpt_count   <= cnt_next;
            rpt_sat     <= sat_next;
`ifdef MATCH_GAP_EN
            rpt_min_gap <= gap_next;
`endif
        end else begin
            if (rpt_valid && rpt_ready) begin
                rpt_valid <= 1'b0;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_match_window_counter.sv
// -----------------------------------------------------------------------------
// tb_seq_match_window_counter
//
// Self-checking bench for seq_match_window_counter. A reference model keeps
// the match positions of the current window in a queue and derives each report
// (count, saturation, minimum gap) from that list; the report register follows
// the load/drop/consume rules. Table-driven windows and hand-written sequences
// cover the corner cases, followed by a randomized run.
// Build with +define+MATCH_GAP_EN to also check rpt_min_gap.
// -----------------------------------------------------------------------------
module tb_seq_match_window_counter;

    localparam int WINDOW   = 16;
    localparam int CW       = 4;
    localparam int GW       = 5;
    localparam int CNT_MAX  = (1 << CW) - 1;
    localparam int GAP_NONE = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          match_in;
    logic          rpt_ready;
    logic          rpt_valid;
    logic [CW-1:0] rpt_count;
    logic          rpt_sat;
    logic          ovf;
`ifdef MATCH_GAP_EN
    logic [GW-1:0] rpt_min_gap;
`endif

    seq_match_window_counter #(
        .WINDOW(WINDOW),
        .CW    (CW),
        .GW    (GW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .match_in   (match_in),
        .rpt_ready  (rpt_ready),
        .rpt_valid  (rpt_valid),
        .rpt_count  (rpt_count),
        .rpt_sat    (rpt_sat),
        .ovf        (ovf)
`ifdef MATCH_GAP_EN
        ,
        .rpt_min_gap(rpt_min_gap)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_run;
    int m_pos;
    int m_hits[$];
    bit e_valid;
    int e_count;
    bit e_sat;
    int e_gap;
    bit e_ovf;

    typedef struct {
        logic [WINDOW-1:0] mask;
        int                count;
        bit                sat;
        int                gap;
    } win_vec_t;

    win_vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_run   = 1'b0;
        m_pos   = 0;
        m_hits.delete();
        e_valid = 1'b0;
        e_count = 0;
        e_sat   = 1'b0;
        e_gap   = GAP_NONE;
        e_ovf   = 1'b0;
    endfunction

    // One clock edge of the specified behaviour, from pre-edge inputs.
    function automatic void model_step(input bit e, input bit m, input bit r);
        bit end_now = 1'b0;
        int f_count = 0;
        bit f_sat   = 1'b0;
        int f_gap   = GAP_NONE;
        if (!m_run) begin
            if (e) m_run = 1'b1;
        end else if (!e) begin
            m_run = 1'b0;
            m_pos = 0;
            m_hits.delete();
        end else begin
            if (m) m_hits.push_back(m_pos);
            if (m_pos == WINDOW - 1) begin
                end_now = 1'b1;
                f_count = (m_hits.size() > CNT_MAX) ? CNT_MAX : m_hits.size();
                f_sat   = (m_hits.size() > CNT_MAX);
                for (int i = 1; i < m_hits.size(); i++) begin
                    if (m_hits[i] - m_hits[i-1] < f_gap) f_gap = m_hits[i] - m_hits[i-1];
                end
                m_pos = 0;
                m_hits.delete();
            end else begin
                m_pos++;
            end
        end
        if (end_now) begin
            if (!e_valid || r) begin
                e_valid = 1'b1;
                e_count = f_count;
                e_sat   = f_sat;
                e_gap   = f_gap;
            end else begin
                e_ovf = 1'b1;
            end
        end else if (e_valid && r) begin
            e_valid = 1'b0;
        end
    endfunction

    task automatic check_model();
        check("model.rpt_valid", 32'(rpt_valid), 32'(e_valid));
        check("model.rpt_count", 32'(rpt_count), 32'(e_count));
        check("model.rpt_sat",   32'(rpt_sat),   32'(e_sat));
        check("model.ovf",       32'(ovf),       32'(e_ovf));
`ifdef MATCH_GAP_EN
        check("model.rpt_min_gap", 32'(rpt_min_gap), 32'(e_gap));
`endif
    endtask

    task automatic expect_report(input string name, input bit v, input int c, input bit s,
                                 input bit o, input int g);
        check({name, ".rpt_valid"}, 32'(rpt_valid), 32'(v));
        check({name, ".rpt_count"}, 32'(rpt_count), 32'(c));
        check({name, ".rpt_sat"},   32'(rpt_sat),   32'(s));
        check({name, ".ovf"},       32'(ovf),       32'(o));
`ifdef MATCH_GAP_EN
        check({name, ".rpt_min_gap"}, 32'(rpt_min_gap), 32'(g));
`else
        if (g < 0) $display("unexpected negative gap for %s", name);
`endif
    endtask

    // Drive one cycle of inputs, advance one edge, compare against the model.
    task automatic step(input bit e, input bit m, input bit r);
        en        = e;
        match_in  = m;
        rpt_ready = r;
        @(posedge clk);
        model_step(e, m, r);
        #1;
        check_model();
    endtask

    task automatic run_window(input logic [WINDOW-1:0] mask, input logic [WINDOW-1:0] rdy);
        for (int p = 0; p < WINDOW; p++) begin
            step(1'b1, mask[p], rdy[p]);
        end
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic do_async_reset(input string name);
        #2;
        reset = 1'b1;
        #1;
        expect_report(name, 1'b0, 0, 1'b0, 1'b0, GAP_NONE);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{mask: 16'h1088, count: 3,  sat: 1'b0, gap: 4};
        vecs[1] = '{mask: 16'hFFFF, count: 15, sat: 1'b1, gap: 1};
        vecs[2] = '{mask: 16'h8001, count: 2,  sat: 1'b0, gap: 15};
        vecs[3] = '{mask: 16'h0000, count: 0,  sat: 1'b0, gap: GAP_NONE};
        vecs[4] = '{mask: 16'h0020, count: 1,  sat: 1'b0, gap: GAP_NONE};

        reset     = 1'b1;
        en        = 1'b0;
        match_in  = 1'b0;
        rpt_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_report("reset", 1'b0, 0, 1'b0, 1'b0, GAP_NONE);
        reset = 1'b0;

        // Table-driven windows, consumer always ready
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            run_window(vecs[i].mask, '1);
            expect_report($sformatf("table[%0d]", i), 1'b1, vecs[i].count, vecs[i].sat, 1'b0,
                          vecs[i].gap);
        end

        // Backpressure: count-2 window held, count-5 window dropped
        run_window(16'h0006, 16'h0001);
        expect_report("bp_first", 1'b1, 2, 1'b0, 1'b0, 1);
        run_window(16'h001F, 16'h0000);
        expect_report("bp_drop", 1'b1, 2, 1'b0, 1'b1, 1);
        step(1'b0, 1'b0, 1'b1);
        expect_report("bp_drain", 1'b0, 2, 1'b0, 1'b1, 1);

        // Async reset mid-window while a report is pending
        step(1'b1, 1'b0, 1'b0);
        run_window(16'h000F, 16'h0000);
        expect_report("pre_reset", 1'b1, 4, 1'b0, 1'b1, 1);
        for (int p = 0; p < 5; p++) step(1'b1, 1'b1, 1'b0);
        do_async_reset("async_reset");
        repeat (3) step(1'b0, 1'b1, 1'b1);
        expect_report("idle_after_reset", 1'b0, 0, 1'b0, 1'b0, GAP_NONE);

        // Simultaneous accept and load
        step(1'b1, 1'b0, 1'b0);
        run_window(16'h000F, 16'h0000);
        expect_report("sim_first", 1'b1, 4, 1'b0, 1'b0, 1);
        run_window(16'h003F, 16'h8000);
        expect_report("sim_accept_load", 1'b1, 6, 1'b0, 1'b0, 1);

        // Enable drop at pos 8 after two matches
        for (int p = 0; p < 8; p++) step(1'b1, (p == 2 || p == 4), (p == 0));
        step(1'b0, 1'b1, 1'b0);
        expect_report("en_drop", 1'b0, 6, 1'b0, 1'b0, 1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_window(16'h0400, 16'h0000);
        expect_report("en_restart", 1'b1, 1, 1'b0, 1'b0, GAP_NONE);

        // Randomized run against the model
        begin
            int dens = 30;
            for (int i = 0; i < 3000; i++) begin
                if (i % 64 == 0) begin
                    dens = ($urandom_range(0, 3) == 0) ? 95 : int'($urandom_range(5, 50));
                end
                if ($urandom_range(0, 599) == 0) do_async_reset("rand_reset");
                step($urandom_range(0, 99) < 96, $urandom_range(0, 99) < dens,
                     $urandom_range(0, 1) == 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
